conv_mac_folded_param: RTL and testbench
========================================

Name: conv_mac_folded_param

Overview:
- Folded K×K convolution engine: one signed multiply-accumulate unit, iterated over all taps by a small FSM, one tap per cycle.
- Next generation of the single-MAC 3x3 edge-detector block. Adds parametrised pixel/coefficient/accumulator widths and kernel size.
- Also adds a runtime-loadable coefficient bank, valid/ready handshakes on input and output, and an optional absolute-value output mode.
- Sits between the window generator (line buffers) and the result sink in the image pipeline.

Parameters:
- DATA_W, 8, pixel width; unsigned.
- COEF_W, 8, coefficient width; signed two's complement.
- K, 3, kernel side; tap count N = K*K; K odd, K >= 3.
- ACC_W, 32, accumulator and result width; signed.
- ABS_OUT, 0, output mode: 0 = signed sum; 1 = absolute value of the sum.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- coef_we  in  1  write strobe for one coefficient.
- coef_addr  in  clog2(N)  coefficient index; row-major, 0 = top-left.
- coef_wdata  in  COEF_W  coefficient value.
- in_valid  in  1  window valid.
- in_ready  out  1  block can accept a window.
- in_window  in  N*DATA_W  tap i at bits [i*DATA_W +: DATA_W]; row-major, tap 0 = top-left.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts the result.
- out_result  out  ACC_W  convolution result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE, tap index = 0, accumulator = 0.
  - out_valid = 0, out_result = 0, in_ready = 1, busy = 0.
  - Coefficient bank reloads the default Laplacian: every tap = +1, centre tap (N-1)/2 = -(N-1). K=3 gives -8; K=5 gives -24.
  - Reset applied in any state aborts the operation in flight; nothing is emitted.
- States: IDLE, RUN, HOLD. in_ready = (state == IDLE).
- IDLE:
  - Acceptance: in_valid && in_ready at edge E0 → capture in_window into the internal window register, acc = 0, idx = 0, go to RUN.
  - in_window is sampled only at acceptance; later changes have no effect on the result.
- RUN:
  - Each edge: acc <= acc + ext(pixel[idx]) * coef[idx]; idx <= idx + 1.
  - Exactly N edges (E1..EN). At EN: out_result <= final sum (after the ABS_OUT transform), out_valid <= 1, go to HOLD.
  - Latency: out_valid is first high after edge E0+N (9 cycles for K=3).
- HOLD:
  - out_valid and out_result are held stable until out_valid && out_ready at an edge; then out_valid <= 0 and state goes to IDLE.
  - out_result keeps its last value after the handshake.
  - Minimum acceptance-to-acceptance period is N+2 edges.
- in_valid while in_ready = 0: ignored; upstream holds the data.
- Coefficient writes:
  - Take effect on the edge when coef_we = 1, only in IDLE.
  - Ignored in RUN and HOLD, so the in-flight kernel is protected.
  - Ignored when coef_addr >= N.
  - If a write and an acceptance occur on the same edge in IDLE, the write lands and the window just accepted uses the new coefficient.
- Arithmetic:
  - Pixel is zero-extended to DATA_W+1 signed bits.
  - Product is signed, DATA_W+COEF_W+1 bits, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; no saturation.
  - No-overflow guarantee requires ACC_W >= DATA_W+COEF_W+1+clog2(N); the bench checks this at elaboration.
- ABS_OUT=1: out_result = |sum|. The value -2^(ACC_W-1) passes through unchanged.
- busy = state != IDLE; it is purely combinational from the state register.

Test Plan:
1. Reset, K=3 defaults; accept window of all taps = 10 → out_result = 0, out_valid rises exactly 9 edges after acceptance, in_ready low during RUN and HOLD.
2. Centre pixel 255, other taps 0 → out_result = -2040 (0xFFFFF808). Same stimulus with ABS_OUT=1 → out_result = 2040.
3. Backpressure:
   - Hold out_ready low for 5 cycles in HOLD → out_valid and out_result stay stable, in_ready stays 0, and a second in_valid pulse is ignored.
   - Raise out_ready → out_valid drops and the block is in IDLE on the next edge.
4. Coefficient load:
   - In IDLE, write coef[0..8] = 2; accept a window with tap i = i+1 → out_result = 90.
   - A coef write issued during RUN leaves the result at 90 and is absent on the next window.
   - A write with coef_addr = 9 is ignored.
5. Reset mid-RUN at idx = 4 → next cycle out_valid = 0, in_ready = 1, busy = 0, and the custom coefficients revert to the default Laplacian (verified by rerunning scenario 1).
6. K=5, ACC_W=32: all pixels 1 → 0; centre 100, others 0 → -2400; out_valid rises 25 edges after acceptance.

Source files
------------

// File: rtl/conv_mac_folded_param.sv
// Folded KxK convolution engine: one signed MAC iterated over all taps, one tap per cycle,
// with a runtime-loadable coefficient bank and valid/ready handshakes on both sides.
module conv_mac_folded_param #(
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 8,
  parameter int K       = 3,
  parameter int ACC_W   = 32,
  parameter int ABS_OUT = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        coef_we,
  input  logic [$clog2(K*K)-1:0]      coef_addr,
  input  logic signed [COEF_W-1:0]    coef_wdata,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [K*K*DATA_W-1:0]       in_window,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_W-1:0]     out_result,
  output logic                        busy
);

  localparam int N  = K * K;
  localparam int AW = $clog2(N);
  localparam int PW = DATA_W + COEF_W + 1;
  localparam int CENTRE = (N - 1) / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [AW-1:0]              idx;
  logic signed [ACC_W-1:0]    acc;
  logic [N*DATA_W-1:0]        window;
  logic signed [COEF_W-1:0]   coef [N];

  logic                       accept;
  logic                       last_tap;
  logic                       coef_wr;
  logic [DATA_W-1:0]          pixel;
  logic signed [ACC_W-1:0]    mac_sum;

  // Unsigned pixel widened by one bit so the signed product cannot misread it as negative.
  function automatic logic signed [ACC_W-1:0] tap_product(
    input logic [DATA_W-1:0]        pix,
    input logic signed [COEF_W-1:0] c
  );
    logic signed [PW-1:0] px_ext;
    logic signed [PW-1:0] c_ext;
    logic signed [PW-1:0] prod;
    px_ext = signed'(PW'(pix));
    c_ext  = PW'(c);
    prod   = px_ext * c_ext;
    return ACC_W'(prod);
  endfunction

  // Most-negative value has no positive counterpart and is passed through unchanged.
  function automatic logic signed [ACC_W-1:0] finish_result(
    input logic signed [ACC_W-1:0] s
  );
    if ((ABS_OUT != 0) && (s < 0)) begin
      return -s;
    end
    return s;
  endfunction

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);

  always_comb begin
    accept    = 1'b0;
    last_tap  = 1'b0;
    coef_wr   = 1'b0;
    pixel     = window[32'(idx) * DATA_W +: DATA_W];
    mac_sum   = acc + tap_product(pixel, coef[idx]);
    state_nxt = state;
    case (state)
      IDLE: begin
        accept  = in_valid;
        coef_wr = coef_we && (32'(coef_addr) < N);
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        last_tap = (idx == AW'(N - 1));
        if (last_tap) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Window is pure data: captured on acceptance only, so upstream may change it freely afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      window <= in_window;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      acc        <= '0;
      out_result <= '0;
      for (int i = 0; i < N; i++) begin
        coef[i] <= (i == CENTRE) ? COEF_W'(1 - N) : COEF_W'(1);
      end
    end else begin
      if (coef_wr) begin
        coef[coef_addr] <= coef_wdata;
      end
      if (accept) begin
        acc <= '0;
        idx <= '0;
      end else if (state == RUN) begin
        acc <= mac_sum;
        idx <= idx + 1'b1;
        if (last_tap) begin
          out_result <= finish_result(mac_sum);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_folded_param.sv
// Bench for conv_mac_folded_param: K=3 signed and absolute-value instances in lockstep plus a K=5
// instance, all checked against an integer dot-product model of the kernel.
module tb_conv_mac_folded_param;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int AccW = 32;
  localparam int N3 = 9;
  localparam int N5 = 25;

  if (AccW < DW + CW + 1 + $clog2(N5)) begin : g_acc_guard
    $error("ACC_W too narrow for the K=5 instance");
  end

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              coef_we;
  logic [3:0]        coef_addr;
  logic [7:0]        coef_wdata;
  logic              in_valid;
  logic [N3*DW-1:0]  in_window;
  logic              out_ready;
  logic              in_ready_s, out_valid_s, busy_s;
  logic [31:0]       out_result_s;
  logic              in_ready_a, out_valid_a, busy_a;
  logic [31:0]       out_result_a;

  logic              rst5;
  logic              coef_we5;
  logic [4:0]        coef_addr5;
  logic [7:0]        coef_wdata5;
  logic              in_valid5;
  logic [N5*DW-1:0]  in_window5;
  logic              out_ready5;
  logic              in_ready5, out_valid5, busy5;
  logic [31:0]       out_result5;

  int n_cmp = 0;
  int n_bad = 0;
  int mcoef3[25];
  int mcoef5[25];

  conv_mac_folded_param #(.DATA_W(DW), .COEF_W(CW), .K(3), .ACC_W(AccW), .ABS_OUT(0)) dut_s (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_window(in_window),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_result(out_result_s), .busy(busy_s));

  conv_mac_folded_param #(.DATA_W(DW), .COEF_W(CW), .K(3), .ACC_W(AccW), .ABS_OUT(1)) dut_a (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_window(in_window),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_result(out_result_a), .busy(busy_a));

  conv_mac_folded_param #(.DATA_W(DW), .COEF_W(CW), .K(5), .ACC_W(AccW), .ABS_OUT(0)) dut_5 (
    .clk(clk), .rst(rst5), .coef_we(coef_we5), .coef_addr(coef_addr5), .coef_wdata(coef_wdata5),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_window(in_window5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_result(out_result5), .busy(busy5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain dot product of pixels and coefficients, wrapped to 32 bits.
  function automatic logic [31:0] model(input int pix[25], input int cf[25], input int n,
                                        input bit absm);
    longint s;
    logic signed [31:0] r;
    s = 0;
    for (int i = 0; i < n; i++) s += longint'(pix[i]) * longint'(cf[i]);
    r = s[31:0];
    if (absm && r < 0) r = -r;
    return r;
  endfunction

  task automatic laplacian(output int cf[25], input int n);
    for (int i = 0; i < 25; i++) cf[i] = 0;
    for (int i = 0; i < n; i++) cf[i] = (i == (n - 1) / 2) ? -(n - 1) : 1;
  endtask

  task automatic write3(input int a, input int v);
    coef_we = 1'b1;
    coef_addr = 4'(a);
    coef_wdata = 8'(v);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic do_window3(input int pix[25], input bit we, input int waddr, input int wval,
                            output int lat, output logic [31:0] res_s, output logic [31:0] res_a,
                            output bit leak, output bit vld_after, output bit rdy_after);
    for (int c = 0; c < 50 && !in_ready_s; c++) tick();
    for (int i = 0; i < N3; i++) in_window[i*DW +: DW] = 8'(pix[i]);
    in_valid = 1'b1;
    coef_we = we;
    coef_addr = 4'(waddr);
    coef_wdata = 8'(wval);
    tick();
    in_valid = 1'b0;
    coef_we = 1'b0;
    in_window = 72'({$urandom(), $urandom(), $urandom()});
    lat = -1;
    leak = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (out_valid_s) begin
        lat = c;
        break;
      end
      if (in_ready_s || in_ready_a || !busy_s) leak = 1'b1;
    end
    res_s = out_result_s;
    res_a = out_result_a;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vld_after = out_valid_s;
    rdy_after = in_ready_s && !busy_s;
  endtask

  task automatic do_window5(input int pix[25], output int lat, output logic [31:0] res);
    for (int c = 0; c < 50 && !in_ready5; c++) tick();
    for (int i = 0; i < N5; i++) in_window5[i*DW +: DW] = 8'(pix[i]);
    in_valid5 = 1'b1;
    tick();
    in_valid5 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (out_valid5) begin
        lat = c;
        break;
      end
    end
    res = out_result5;
    out_ready5 = 1'b1;
    tick();
    out_ready5 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    laplacian(mcoef3, N3);
    n_cmp++; if ({out_valid_s, out_valid_a} !== 2'b00) begin n_bad++;
      $display("FAIL reset_out_valid: got %b want 00", {out_valid_s, out_valid_a}); end
    n_cmp++; if (out_result_s !== 32'd0) begin n_bad++;
      $display("FAIL reset_out_result: got %0d want 0", out_result_s); end
    n_cmp++; if ({in_ready_s, busy_s, in_ready_a, busy_a} !== 4'b1010) begin n_bad++;
      $display("FAIL reset_ready_busy: got %b want 1010", {in_ready_s, busy_s, in_ready_a, busy_a}); end
  endtask

  task automatic test_default_kernel();
    int pix[25];
    int lat;
    logic [31:0] rs, ra;
    bit leak, va, ra_ok;
    for (int i = 0; i < 25; i++) pix[i] = (i < N3) ? 10 : 0;
    do_window3(pix, 1'b0, 0, 0, lat, rs, ra, leak, va, ra_ok);
    n_cmp++; if (rs !== 32'd0) begin n_bad++;
      $display("FAIL flat10_result: got %0d want 0", $signed(rs)); end
    n_cmp++; if (lat !== 9) begin n_bad++;
      $display("FAIL flat10_latency: got %0d want 9", lat); end
    n_cmp++; if (leak !== 1'b0) begin n_bad++;
      $display("FAIL flat10_ready_low: got in_ready high or busy low during run"); end
    n_cmp++; if ({va, ra_ok} !== 2'b01) begin n_bad++;
      $display("FAIL flat10_release: got valid/idle %b want 01", {va, ra_ok}); end
    for (int i = 0; i < 25; i++) pix[i] = 0;
    pix[4] = 255;
    do_window3(pix, 1'b0, 0, 0, lat, rs, ra, leak, va, ra_ok);
    n_cmp++; if (rs !== 32'hFFFFF808) begin n_bad++;
      $display("FAIL centre255_signed: got %0d want -2040", $signed(rs)); end
    n_cmp++; if (ra !== 32'd2040) begin n_bad++;
      $display("FAIL centre255_abs: got %0d want 2040", ra); end
    n_cmp++; if (out_result_s !== 32'hFFFFF808) begin n_bad++;
      $display("FAIL result_kept_after_handshake: got %0d want -2040", $signed(out_result_s)); end
  endtask

  task automatic test_backpressure();
    int pix[25];
    logic [31:0] exp_v, held;
    bit got;
    for (int i = 0; i < 25; i++) pix[i] = (i < N3) ? int'($urandom_range(255)) : 0;
    exp_v = model(pix, mcoef3, N3, 1'b0);
    for (int i = 0; i < N3; i++) in_window[i*DW +: DW] = 8'(pix[i]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (out_valid_s) begin got = 1'b1; break; end
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++;
      $display("FAIL bp_valid_timeout: out_valid never rose within 100 cycles"); end
    held = out_result_s;
    n_cmp++; if (held !== exp_v) begin n_bad++;
      $display("FAIL bp_result: got %0d want %0d", $signed(held), $signed(exp_v)); end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        in_valid = 1'b1;
        in_window = 72'({$urandom(), $urandom(), $urandom()});
      end
      tick();
      in_valid = 1'b0;
      n_cmp++; if ({out_valid_s, in_ready_s} !== 2'b10 || out_result_s !== held) begin n_bad++;
        $display("FAIL bp_hold: got valid/ready %b result %0d want 10 result %0d",
                 {out_valid_s, in_ready_s}, $signed(out_result_s), $signed(held)); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if ({out_valid_s, in_ready_s, busy_s} !== 3'b010) begin n_bad++;
      $display("FAIL bp_release: got valid/ready/busy %b want 010", {out_valid_s, in_ready_s, busy_s}); end
    tick();
    n_cmp++; if (busy_s !== 1'b0) begin n_bad++;
      $display("FAIL bp_ignored_pulse: got busy %b want 0", busy_s); end
  endtask

  task automatic test_coef_load();
    int pix[25];
    int lat;
    logic [31:0] rs, ra;
    bit leak, va, ra_ok, got;
    for (int i = 0; i < N3; i++) begin
      write3(i, 2);
      mcoef3[i] = 2;
    end
    for (int i = 0; i < 25; i++) pix[i] = (i < N3) ? i + 1 : 0;
    do_window3(pix, 1'b0, 0, 0, lat, rs, ra, leak, va, ra_ok);
    n_cmp++; if (rs !== 32'd90) begin n_bad++;
      $display("FAIL coef2_result: got %0d want 90", $signed(rs)); end
    for (int i = 0; i < N3; i++) in_window[i*DW +: DW] = 8'(pix[i]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    write3(0, 100);
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (out_valid_s) begin got = 1'b1; break; end
      tick();
    end
    n_cmp++; if (got !== 1'b1 || out_result_s !== 32'd90) begin n_bad++;
      $display("FAIL coef_write_in_run: got valid %b result %0d want 1 90", got, $signed(out_result_s)); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    write3(9, 50);
    do_window3(pix, 1'b0, 0, 0, lat, rs, ra, leak, va, ra_ok);
    n_cmp++; if (rs !== 32'd90) begin n_bad++;
      $display("FAIL coef_run_write_absent: got %0d want 90", $signed(rs)); end
    do_window3(pix, 1'b1, 4, -3, lat, rs, ra, leak, va, ra_ok);
    mcoef3[4] = -3;
    n_cmp++; if (rs !== 32'd65) begin n_bad++;
      $display("FAIL coef_same_edge_write: got %0d want 65", $signed(rs)); end
  endtask

  task automatic test_random();
    int pix[25];
    int lat, a, v, nw;
    logic [31:0] rs, ra, es, ea;
    bit leak, va, ra_ok;
    for (int t = 0; t < 10; t++) begin
      nw = int'($urandom_range(3));
      for (int w = 0; w < nw; w++) begin
        a = int'($urandom_range(15));
        v = int'($urandom_range(255)) - 128;
        write3(a, v);
        if (a < N3) mcoef3[a] = v;
      end
      for (int i = 0; i < 25; i++) pix[i] = (i < N3) ? int'($urandom_range(255)) : 0;
      es = model(pix, mcoef3, N3, 1'b0);
      ea = model(pix, mcoef3, N3, 1'b1);
      do_window3(pix, 1'b0, 0, 0, lat, rs, ra, leak, va, ra_ok);
      n_cmp++; if (rs !== es || ra !== ea) begin n_bad++;
        $display("FAIL random_%0d: got %0d/%0d want %0d/%0d", t, $signed(rs), ra, $signed(es), ea); end
    end
  endtask

  task automatic test_back_to_back();
    int pix[25];
    int t_prev, hits;
    logic [31:0] es;
    for (int i = 0; i < 25; i++) pix[i] = (i < N3) ? int'($urandom_range(255)) : 0;
    es = model(pix, mcoef3, N3, 1'b0);
    for (int i = 0; i < N3; i++) in_window[i*DW +: DW] = 8'(pix[i]);
    in_valid = 1'b1;
    out_ready = 1'b1;
    t_prev = -1;
    hits = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (out_valid_s) begin
        hits++;
        n_cmp++; if (out_result_s !== es) begin n_bad++;
          $display("FAIL b2b_result: got %0d want %0d", $signed(out_result_s), $signed(es)); end
        if (t_prev >= 0) begin
          n_cmp++; if (c - t_prev !== 11) begin n_bad++;
            $display("FAIL b2b_period: got %0d want 11", c - t_prev); end
        end
        t_prev = c;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (hits !== 3) begin n_bad++;
      $display("FAIL b2b_count: got %0d results want 3", hits); end
    for (int c = 0; c < 30; c++) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int pix[25];
    int lat;
    logic [31:0] rs, ra;
    bit leak, va, ra_ok, spurious;
    for (int i = 0; i < N3; i++) in_window[i*DW +: DW] = 8'($urandom_range(255));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    laplacian(mcoef3, N3);
    n_cmp++; if ({out_valid_s, in_ready_s, busy_s} !== 3'b010) begin n_bad++;
      $display("FAIL midrun_reset: got valid/ready/busy %b want 010", {out_valid_s, in_ready_s, busy_s}); end
    spurious = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (out_valid_s || busy_s) spurious = 1'b1;
    end
    n_cmp++; if (spurious !== 1'b0) begin n_bad++;
      $display("FAIL midrun_no_emit: got activity after reset want none"); end
    for (int i = 0; i < 25; i++) pix[i] = (i < N3) ? 10 : 0;
    do_window3(pix, 1'b0, 0, 0, lat, rs, ra, leak, va, ra_ok);
    n_cmp++; if (rs !== 32'd0) begin n_bad++;
      $display("FAIL midrun_default_flat: got %0d want 0", $signed(rs)); end
    for (int i = 0; i < 25; i++) pix[i] = 0;
    pix[4] = 255;
    do_window3(pix, 1'b0, 0, 0, lat, rs, ra, leak, va, ra_ok);
    n_cmp++; if (rs !== model(pix, mcoef3, N3, 1'b0) || rs !== 32'hFFFFF808) begin n_bad++;
      $display("FAIL midrun_default_centre: got %0d want -2040", $signed(rs)); end
  endtask

  task automatic test_k5();
    int pix[25];
    int lat;
    logic [31:0] res;
    rst5 = 1'b1;
    tick();
    tick();
    rst5 = 1'b0;
    laplacian(mcoef5, N5);
    n_cmp++; if ({out_valid5, in_ready5, busy5} !== 3'b010 || out_result5 !== 32'd0) begin n_bad++;
      $display("FAIL k5_reset: got valid/ready/busy %b result %0d want 010 0",
               {out_valid5, in_ready5, busy5}, out_result5); end
    for (int i = 0; i < 25; i++) pix[i] = 1;
    do_window5(pix, lat, res);
    n_cmp++; if (res !== model(pix, mcoef5, N5, 1'b0) || res !== 32'd0) begin n_bad++;
      $display("FAIL k5_flat: got %0d want 0", $signed(res)); end
    n_cmp++; if (lat !== 25) begin n_bad++;
      $display("FAIL k5_latency: got %0d want 25", lat); end
    for (int i = 0; i < 25; i++) pix[i] = 0;
    pix[12] = 100;
    do_window5(pix, lat, res);
    n_cmp++; if (res !== 32'(-2400)) begin n_bad++;
      $display("FAIL k5_centre: got %0d want -2400", $signed(res)); end
  endtask

  initial begin
    rst = 1'b1;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    in_valid = 1'b0;
    in_window = '0;
    out_ready = 1'b0;
    rst5 = 1'b1;
    coef_we5 = 1'b0;
    coef_addr5 = '0;
    coef_wdata5 = '0;
    in_valid5 = 1'b0;
    in_window5 = '0;
    out_ready5 = 1'b0;
    test_reset();
    test_default_kernel();
    test_backpressure();
    test_coef_load();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_k5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
